minv_result_reader: RTL and testbench

Readout engine on the consumer side of the minv flag register. When the inversion datapath signals completion, it decodes the stored 2-bit location flag and selects the register holding the modular inverse (regx1, regx2 or regt). It snapshots that register and streams the result out word-serially over a valid/ready interface to the host/bus side. It never writes the flag; it only reads it.

---
 rtl/minv_result_reader_if.sv | 23 ++
 rtl/minv_result_reader.sv | 111 +++++++++++
 tb/tb_minv_result_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minv_result_reader_if.sv
// rtl/minv_result_reader_if.sv - word-serial result stream between the minv readout engine and its consumer
interface minv_result_reader_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/minv_result_reader.sv
// rtl/minv_result_reader.sv - decodes the minv location flag, snapshots the inverse and streams it LSW first
module minv_result_reader #(
    parameter int WIDTH = 256,
    parameter int WORD  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_minv_flag,
    input  logic [WIDTH-1:0]    i_regx1,
    input  logic [WIDTH-1:0]    i_regx2,
    input  logic [WIDTH-1:0]    i_regt,
    minv_result_reader_if.master m_out,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_flag_err
);
    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_buf;
    logic [CW-1:0]    r_cnt;
    logic [WORD-1:0]  r_dout;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic             r_flag_err;

    logic [WIDTH-1:0] w_sel;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WORD-1:0]  w_next_word;
    logic             w_xfer;

    // Flag decode: 00 -> x1, 01 -> x2, 11 -> t; 10 is rejected before capture so its arm is irrelevant
    always_comb begin
        w_sel = i_regt;
        case (i_minv_flag)
            2'b00:   w_sel = i_regx1;
            2'b01:   w_sel = i_regx2;
            default: w_sel = i_regt;
        endcase
    end

    // Next word is pre-selected from the frozen buffer so a new word follows every accepted one without bubbles
    always_comb begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_next_word = r_buf[int'(w_cnt_nxt) * WORD +: WORD];
        w_xfer      = r_valid && m_out.dout_ready;
    end

    // Readout FSM: capture on start in IDLE, then one word per accepted handshake until the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_flag_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_flag_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_minv_flag == 2'b10) begin
                            r_flag_err <= 1'b1;
                        end else begin
                            r_buf   <= w_sel;
                            r_cnt   <= '0;
                            r_dout  <= w_sel[WORD-1:0];
                            r_valid <= 1'b1;
                            r_last  <= (NWORDS == 1);
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    // start is deliberately ignored here: the buffer must not change mid-stream
                    if (w_xfer) begin
                        if (r_cnt == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt  <= w_cnt_nxt;
                            r_dout <= w_next_word;
                            r_last <= (w_cnt_nxt == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign m_out.dout       = r_dout;
    assign m_out.dout_valid = r_valid;
    assign m_out.dout_last  = r_last && r_valid;
    assign o_busy           = (r_state == S_SEND);
    assign o_done           = r_done;
    assign o_flag_err       = r_flag_err;
endmodule

// File: tb/tb_minv_result_reader.sv
// tb/tb_minv_result_reader.sv - directed self-checking bench for minv_result_reader
module tb_minv_result_reader;
    localparam int WIDTH = 256;
    localparam int WORD  = 32;
    localparam int NW    = WIDTH / WORD;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       flag;
    logic [WIDTH-1:0] rx1, rx2, rt;
    logic             busy, done, ferr;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    minv_result_reader_if #(.WORD(WORD)) bus ();

    minv_result_reader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_minv_flag(flag),
        .i_regx1    (rx1),
        .i_regx2    (rx2),
        .i_regt     (rt),
        .m_out      (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_flag_err (ferr)
    );

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b l=%b b=%b d=%b e=%b expected all 0",
                     bus.dout_valid, bus.dout_last, busy, done, ferr);
        end
        checks++;
        if (bus.dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 00000000", bus.dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_flag_select;
        logic [WIDTH-1:0] exp;
        logic [1:0]       f;
        int               dones;
        rx1 = {192'h0, 64'h0000_0001_0000_0002};
        rx2 = {8{32'hA5A5_A5A5}};
        rt  = {8{32'h3C3C_3C3C}};
        for (int s = 0; s < 3; s++) begin
            f   = (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b11;
            exp = (s == 0) ? {192'h0, 64'h0000_0001_0000_0002} :
                  (s == 1) ? {8{32'hA5A5_A5A5}} : {8{32'h3C3C_3C3C}};
            @(negedge clk);
            bus.dout_ready = 1'b1; start = 1'b1; flag = f;
            @(negedge clk);
            start = 1'b0;
            dones = 0;
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (bus.dout_valid !== 1'b1 || bus.dout !== exp[k*WORD +: WORD] ||
                    bus.dout_last !== (k == NW - 1) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL sel%0d_word%0d: got v=%b d=%h l=%b b=%b expected v=1 d=%h l=%b b=1",
                             s, k, bus.dout_valid, bus.dout, bus.dout_last, busy,
                             exp[k*WORD +: WORD], (k == NW - 1));
                end
                if (done === 1'b1) dones++;
                @(negedge clk);
            end
            checks++;
            if (bus.dout_valid !== 1'b0 || done !== 1'b1 || dones != 0) begin
                errors++;
                $display("FAIL sel%0d_done: got v=%b done=%b early_dones=%0d expected v=0 done=1 early_dones=0",
                         s, bus.dout_valid, done, dones);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL sel%0d_done_pulse: got done=%b busy=%b expected 0 0", s, done, busy);
            end
        end
    endtask

    task automatic test_illegal_flag;
        @(negedge clk);
        start = 1'b1; flag = 2'b10;
        @(negedge clk);
        start = 1'b0; flag = 2'b00;
        checks++;
        if (ferr !== 1'b1 || busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err: got e=%b b=%b v=%b expected e=1 b=0 v=0", ferr, busy, bus.dout_valid);
        end
        @(negedge clk);
        checks++;
        if (ferr !== 1'b0 || busy !== 1'b0 || bus.dout_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after: got e=%b b=%b v=%b d=%b expected all 0",
                     ferr, busy, bus.dout_valid, done);
        end
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] exp;
        logic [15:0]      pat = 16'b1011_0110_1101_0011;
        int               k = 0, low = 0, cyc = 0;
        logic             r;
        for (int i = 0; i < NW; i++) rt[i*WORD +: WORD] = 32'hC0DE_0000 | 32'(i);
        exp = rt;
        @(negedge clk);
        bus.dout_ready = 1'b0; start = 1'b1; flag = 2'b11;
        @(negedge clk);
        start = 1'b0;
        while (k < NW && cyc < 100) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp[k*WORD +: WORD] ||
                bus.dout_last !== (k == NW - 1)) begin
                errors++;
                $display("FAIL bp_word%0d_cyc%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         k, cyc, bus.dout_valid, bus.dout, bus.dout_last,
                         exp[k*WORD +: WORD], (k == NW - 1));
            end
            if (k == 3 && low < 5) begin
                r = 1'b0;
                low++;
            end else begin
                r = pat[cyc % 16];
            end
            bus.dout_ready = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        checks++;
        if (k != NW || bus.dout_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_end: got words=%0d v=%b done=%b expected words=%0d v=0 done=1",
                     k, bus.dout_valid, done, NW);
        end
        bus.dout_ready = 1'b1;
    endtask

    task automatic test_snapshot;
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < NW; i++) rt[i*WORD +: WORD] = 32'h5EED_0000 | 32'(i);
        exp = rt;
        @(negedge clk);
        bus.dout_ready = 1'b1; start = 1'b1; flag = 2'b11;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp[k*WORD +: WORD] || ferr !== 1'b0) begin
                errors++;
                $display("FAIL snap_word%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0",
                         k, bus.dout_valid, bus.dout, ferr, exp[k*WORD +: WORD]);
            end
            if (k == 2) begin
                rt = '0; start = 1'b1; flag = 2'b00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (bus.dout_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL snap_done: got v=%b done=%b expected v=0 done=1", bus.dout_valid, done);
        end
        @(negedge clk);
        checks++;
        if (bus.dout_valid !== 1'b0 || busy !== 1'b0 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL snap_norestart: got v=%b b=%b e=%b expected 0 0 0", bus.dout_valid, busy, ferr);
        end
    endtask

    task automatic test_reset_mid;
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < NW; i++) rt[i*WORD +: WORD] = 32'h7A7A_0000 | 32'(i);
        for (int i = 0; i < NW; i++) rx2[i*WORD +: WORD] = 32'hB0B0_0000 | 32'(i);
        exp = rx2;
        @(negedge clk);
        bus.dout_ready = 1'b1; start = 1'b1; flag = 2'b11;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.dout_valid !== 1'b0 || busy !== 1'b0 || bus.dout_last !== 1'b0 || bus.dout !== 32'h0) begin
            errors++;
            $display("FAIL rstmid: got v=%b b=%b l=%b d=%h expected v=0 b=0 l=0 d=00000000",
                     bus.dout_valid, busy, bus.dout_last, bus.dout);
        end
        rst = 1'b0;
        start = 1'b1; flag = 2'b01;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp[k*WORD +: WORD] ||
                bus.dout_last !== (k == NW - 1)) begin
                errors++;
                $display("FAIL rstmid_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         k, bus.dout_valid, bus.dout, bus.dout_last, exp[k*WORD +: WORD], (k == NW - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: got %b expected 1", done);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] e1, e2;
        for (int i = 0; i < NW; i++) rx1[i*WORD +: WORD] = 32'hA1A1_0000 | 32'(i);
        for (int i = 0; i < NW; i++) rt[i*WORD +: WORD]  = 32'hD7D7_0000 | 32'(i);
        e1 = rx1;
        e2 = rt;
        @(negedge clk);
        bus.dout_ready = 1'b1; start = 1'b1; flag = 2'b00;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== e1[k*WORD +: WORD]) begin
                errors++;
                $display("FAIL b2b_a_word%0d: got v=%b d=%h expected v=1 d=%h",
                         k, bus.dout_valid, bus.dout, e1[k*WORD +: WORD]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 1", done);
        end
        start = 1'b1; flag = 2'b11;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== e2[k*WORD +: WORD] ||
                bus.dout_last !== (k == NW - 1)) begin
                errors++;
                $display("FAIL b2b_b_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         k, bus.dout_valid, bus.dout, bus.dout_last, e2[k*WORD +: WORD], (k == NW - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got done=%b v=%b expected done=1 v=0", done, bus.dout_valid);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flag = 2'b00;
        rx1 = '0; rx2 = '0; rt = '0;
        bus.dout_ready = 1'b0;
        test_reset;
        test_flag_select;
        test_illegal_flag;
        test_backpressure;
        test_snapshot;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
